alu_ctrl_rv32i: RTL and testbench



---
 rtl/alu_ctrl_rv32i.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_ctrl_rv32i.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_rv32i.sv
// RV32I execute-issue stage: decodes an instruction into ALU selector/operands and holds it
// in a registered valid/ready slot. Optional skid register enabled by `ALU_CTRL_SKID_EN.
module alu_ctrl_rv32i #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_rs1,
    input  logic [W-1:0] in_rs2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_alu_sel,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_store_data,
    output logic         out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_SLL  = 4'd2;
    localparam logic [3:0] SEL_SLT  = 4'd3;
    localparam logic [3:0] SEL_SLTU = 4'd4;
    localparam logic [3:0] SEL_XOR  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_SRA  = 4'd7;
    localparam logic [3:0] SEL_OR   = 4'd8;
    localparam logic [3:0] SEL_AND  = 4'd9;

    typedef struct packed {
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sd;
        logic         ill;
    } bundle_t;

    function automatic logic [W-1:0] sext32(input logic [31:0] v);
        return W'($signed(v));
    endfunction

    // Base (funct7 = 0) operation for a funct3 value, shared by R-type and I-ALU.
    function automatic logic [3:0] base_sel(input logic [2:0] f3);
        logic [3:0] s;
        case (f3)
            3'b000:  s = SEL_ADD;
            3'b001:  s = SEL_SLL;
            3'b010:  s = SEL_SLT;
            3'b011:  s = SEL_SLTU;
            3'b100:  s = SEL_XOR;
            3'b101:  s = SEL_SRL;
            3'b110:  s = SEL_OR;
            3'b111:  s = SEL_AND;
            default: s = SEL_ADD;
        endcase
        return s;
    endfunction

    function automatic bundle_t decode(input logic [31:0]  ins,
                                       input logic [W-1:0] pc,
                                       input logic [W-1:0] rs1,
                                       input logic [W-1:0] rs2);
        bundle_t     d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d.sel = SEL_ADD;
        d.a   = rs1;
        d.b   = sext32(imm_i);
        d.sd  = rs2;
        d.ill = 1'b0;
        case (ins[6:0])
            OP_R: begin
                d.b = rs2;
                if (f7 == F7_BASE) begin
                    d.sel = base_sel(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d.sel = SEL_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d.sel = SEL_SRA;
                end else begin
                    d.ill = 1'b1;
                end
            end
            OP_I_ALU: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.b = {{(W-5){1'b0}}, ins[24:20]};
                    if (f7 == F7_BASE) begin
                        d.sel = base_sel(f3);
                    end else if (f7 == F7_ALT && f3 == 3'b101) begin
                        d.sel = SEL_SRA;
                    end else begin
                        d.ill = 1'b1;
                    end
                end else begin
                    d.sel = base_sel(f3);
                end
            end
            OP_LOAD, OP_JALR: begin
                d.sel = SEL_ADD;
            end
            OP_STORE: begin
                d.b = sext32(imm_s);
            end
            OP_BRANCH: begin
                d.b = rs2;
                case (f3)
                    3'b000, 3'b001: d.sel = SEL_SUB;
                    3'b100, 3'b101: d.sel = SEL_SLT;
                    3'b110, 3'b111: d.sel = SEL_SLTU;
                    default:        d.ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                d.a = {W{1'b0}};
                d.b = sext32(imm_u);
            end
            OP_AUIPC: begin
                d.a = pc;
                d.b = sext32(imm_u);
            end
            OP_JAL: begin
                d.a = pc;
                d.b = sext32(imm_j);
            end
            default: begin
                d.ill = 1'b1;
            end
        endcase
        // Illegal bundles carry a neutral ADD 0,0 so the ALU result is harmless.
        if (d.ill) begin
            d.sel = SEL_ADD;
            d.a   = {W{1'b0}};
            d.b   = {W{1'b0}};
        end else begin
            d.sel = d.sel;
        end
        return d;
    endfunction

    bundle_t dec_s;
    bundle_t main_r;
    logic    main_valid_r;
    logic    push_s;
    logic    pop_s;

    assign dec_s  = decode(in_instr, in_pc, in_rs1, in_rs2);
    assign push_s = in_valid & in_ready;
    assign pop_s  = main_valid_r & out_ready;

    assign out_valid      = main_valid_r;
    assign out_alu_sel    = main_r.sel;
    assign out_a          = main_r.a;
    assign out_b          = main_r.b;
    assign out_store_data = main_r.sd;
    assign out_illegal    = main_r.ill;

`ifdef ALU_CTRL_SKID_EN
    bundle_t skid_r;
    logic    skid_valid_r;
    bundle_t main_nxt_s;
    bundle_t skid_nxt_s;
    logic    main_valid_nxt_s;
    logic    skid_valid_nxt_s;

    // The skid-valid flop alone decides readiness; reset forces it low while asserted.
    assign in_ready = rst_n & ~skid_valid_r;

    // Next-state for main and skid slots; the skid slot always drains into main first.
    always_comb begin
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (pop_s) begin
            if (skid_valid_r) begin
                main_nxt_s       = skid_r;
                main_valid_nxt_s = 1'b1;
                if (push_s) begin
                    skid_nxt_s       = dec_s;
                    skid_valid_nxt_s = 1'b1;
                end else begin
                    skid_valid_nxt_s = 1'b0;
                end
            end else if (push_s) begin
                main_nxt_s       = dec_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (!main_valid_r) begin
            if (push_s) begin
                main_nxt_s       = dec_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (push_s) begin
            skid_nxt_s       = dec_s;
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_r       <= main_nxt_s;
            skid_r       <= skid_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end
`else
    // Single slot: a new bundle may enter whenever the held one leaves this cycle.
    assign in_ready = rst_n & (out_ready | ~main_valid_r);

    // Single slot register; a simultaneous accept/leave replaces the bundle without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            main_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
        end else if (push_s) begin
            main_r       <= dec_s;
            main_valid_r <= 1'b1;
        end else if (pop_s) begin
            main_valid_r <= 1'b0;
        end else begin
            main_valid_r <= main_valid_r;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_rv32i.sv
// Self-checking bench for alu_ctrl_rv32i: constant vector table, hand sequences and a
// randomized stream compared against a queue-based reference model.
module tb_alu_ctrl_rv32i;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_rs1 = 32'h0;
    logic [31:0] in_rs2 = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_sel;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_store_data;
    logic        out_illegal;

    alu_ctrl_rv32i #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_sel(out_alu_sel),
        .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    logic [31:0] obs_b[$];
    logic rec = 1'b0;
    logic prev_stall = 1'b0;
    exp_t prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
`ifdef ALU_CTRL_SKID_EN
        return q.size() < 2;
`else
        return out_ready || q.size() == 0;
`endif
    endfunction

    // Reference decode written from the ISA rules.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        int f3;
        int f7;
        logic [3:0] r_ops[8];
        logic [31:0] ii;
        logic [31:0] si;
        logic [31:0] ui;
        logic [31:0] ji;
        r_ops = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        ii = 32'($signed(ins[31:20]));
        si = 32'($signed({ins[31:25], ins[11:7]}));
        ui = ins & 32'hFFFFF000;
        ji = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e.sd = rs2; e.ill = 1'b0; e.sel = 4'd0; e.a = rs1; e.b = ii;
        case (ins[6:0])
            7'h33: begin
                e.b = rs2;
                if (f7 == 0) e.sel = r_ops[f3];
                else if (f7 == 32 && f3 == 0) e.sel = 4'd1;
                else if (f7 == 32 && f3 == 5) e.sel = 4'd7;
                else e.ill = 1'b1;
            end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    e.b = {27'h0, ins[24:20]};
                    if (f7 == 0) e.sel = r_ops[f3];
                    else if (f7 == 32 && f3 == 5) e.sel = 4'd7;
                    else e.ill = 1'b1;
                end else e.sel = r_ops[f3];
            end
            7'h03, 7'h67: e.sel = 4'd0;
            7'h23: e.b = si;
            7'h63: begin
                e.b = rs2;
                if (f3 == 2 || f3 == 3) e.ill = 1'b1;
                else if (f3 < 2) e.sel = 4'd1;
                else if (f3 < 6) e.sel = 4'd3;
                else e.sel = 4'd4;
            end
            7'h37: begin e.a = 32'h0; e.b = ui; end
            7'h17: begin e.a = pc;    e.b = ui; end
            7'h6F: begin e.a = pc;    e.b = ji; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.sel = 4'd0; e.a = 32'h0; e.b = 32'h0; end
        return e;
    endfunction

    // Scoreboard check, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {31'h0, in_ready}, {31'h0, model_ready()});
            check("out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
            if (q.size() > 0) begin
                check("sb_sel", {28'h0, out_alu_sel}, {28'h0, q[0].sel});
                check("sb_a", out_a, q[0].a);
                check("sb_b", out_b, q[0].b);
                check("sb_store", out_store_data, q[0].sd);
                check("sb_illegal", {31'h0, out_illegal}, {31'h0, q[0].ill});
            end
            if (prev_stall && out_valid) begin
                check("stall_a", out_a, prev_out.a);
                check("stall_b", out_b, prev_out.b);
                check("stall_sel", {28'h0, out_alu_sel}, {28'h0, prev_out.sel});
            end
            if (rec && out_valid && out_ready) obs_b.push_back(out_b);
            prev_stall = out_valid && !out_ready && !flush;
            prev_out.a = out_a; prev_out.b = out_b; prev_out.sel = out_alu_sel;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference model update at each active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            logic push;
            logic pop;
            push = in_valid && model_ready();
            pop  = q.size() > 0 && out_ready;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(ref_dec(in_instr, in_pc, in_rs1, in_rs2));
            end
        end
    end

    always @(negedge rst_n) q.delete();

    function automatic logic [31:0] addi(input int imm);
        return (32'(imm) << 20) | 32'h00000093;
    endfunction

    vec_t tbl[16];
    logic pat[4];

    initial begin
        tbl[0]  = '{32'h002081B3, 32'h0,   32'd5,        32'd7,  4'd0, 32'd5,        32'd7,        1'b0};
        tbl[1]  = '{32'h4030D093, 32'h0,   32'h80000000, 32'd1,  4'd7, 32'h80000000, 32'd3,        1'b0};
        tbl[2]  = '{32'hFE30D093, 32'h0,   32'h80000000, 32'd1,  4'd0, 32'h0,        32'h0,        1'b1};
        tbl[3]  = '{32'h12345097, 32'h100, 32'd9,        32'd2,  4'd0, 32'h100,      32'h12345000, 1'b0};
        tbl[4]  = '{32'h123450B7, 32'h100, 32'd9,        32'd2,  4'd0, 32'h0,        32'h12345000, 1'b0};
        tbl[5]  = '{32'h402081B3, 32'h0,   32'd5,        32'd7,  4'd1, 32'd5,        32'd7,        1'b0};
        tbl[6]  = '{32'h402091B3, 32'h0,   32'd5,        32'd7,  4'd0, 32'h0,        32'h0,        1'b1};
        tbl[7]  = '{32'hFFF08093, 32'h0,   32'd3,        32'd4,  4'd0, 32'd3,        32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{32'h0020E063, 32'h0,   32'd11,       32'd12, 4'd4, 32'd11,       32'd12,       1'b0};
        tbl[9]  = '{32'h0020A063, 32'h0,   32'd11,       32'd12, 4'd0, 32'h0,        32'h0,        1'b1};
        tbl[10] = '{32'hFE20AE23, 32'h0,   32'h1000,     32'hAB, 4'd0, 32'h1000,     32'hFFFFFFFC, 1'b0};
        tbl[11] = '{32'h0080006F, 32'h200, 32'd1,        32'd2,  4'd0, 32'h200,      32'd8,        1'b0};
        tbl[12] = '{32'h0000007F, 32'h0,   32'd1,        32'd2,  4'd0, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{32'h40109093, 32'h0,   32'd1,        32'd2,  4'd0, 32'h0,        32'h0,        1'b1};
        tbl[14] = '{32'h80012083, 32'h0,   32'h40,       32'd2,  4'd0, 32'h40,       32'hFFFFF800, 1'b0};
        tbl[15] = '{32'h0050B093, 32'h0,   32'd6,        32'd2,  4'd4, 32'd6,        32'd5,        1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_sel", {28'h0, out_alu_sel}, 32'h0);
        check("rst_a", out_a, 32'h0);
        check("rst_b", out_b, 32'h0);
        check("rst_store", out_store_data, 32'h0);
        check("rst_illegal", {31'h0, out_illegal}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Table vectors, one per transfer with the ALU stage always ready.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_instr = tbl[i].ins; in_pc = tbl[i].pc;
            in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("tbl%0d_sel", i), {28'h0, out_alu_sel}, {28'h0, tbl[i].sel});
            check($sformatf("tbl%0d_a", i), out_a, tbl[i].a);
            check($sformatf("tbl%0d_b", i), out_b, tbl[i].b);
            check($sformatf("tbl%0d_store", i), out_store_data, tbl[i].rs2);
            check($sformatf("tbl%0d_illegal", i), {31'h0, out_illegal}, {31'h0, tbl[i].ill});
        end

        // Backpressure: 8 back-to-back ADDIs with out_ready cycling 1,0,0,1.
        begin
            int idx;
            int cyc;
            int guard;
            logic acc;
            @(posedge clk); #1;
            obs_b.delete(); rec = 1'b1; idx = 1; cyc = 0; guard = 0;
            in_rs1 = 32'h0; in_valid = 1'b1; in_instr = addi(1); out_ready = pat[0];
            while (idx <= 8 && guard < 200) begin
                @(negedge clk); acc = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++; guard++; out_ready = pat[cyc % 4];
                if (acc) begin
                    idx++;
                    if (idx <= 8) in_instr = addi(idx);
                    else in_valid = 1'b0;
                end
            end
            check("bp_accept_bound", 32'(idx), 32'd9);
            in_valid = 1'b0;
            guard = 0;
            while (obs_b.size() < 8 && guard < 50) begin
                @(posedge clk); #1; cyc++; guard++; out_ready = pat[cyc % 4];
            end
            repeat (4) begin @(posedge clk); #1 out_ready = 1'b1; end
            rec = 1'b0;
            check("bp_transfers", 32'(obs_b.size()), 32'd8);
            for (int k = 0; k < 8; k++)
                if (k < obs_b.size()) check($sformatf("bp_b%0d", k), obs_b[k], 32'(k + 1));
        end

        // Flush drops held bundles and the input presented with it.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = addi(85);
        @(posedge clk); #1 in_instr = addi(86);
        @(posedge clk); #1 flush = 1'b1; in_instr = addi(87);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_no_replay", {31'h0, out_valid}, 32'h0);
        end

        // Asynchronous reset between edges.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = addi(5);
        @(posedge clk); #1 in_instr = addi(6);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        check("arst_in_ready", {31'h0, in_ready}, 32'h0);
        check("arst_b", out_b, 32'h0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_replay", {31'h0, out_valid}, 32'h0);
        end

        // Randomized stream against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [6:0] ops[10];
            logic [31:0] ins;
            int pick;
            ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
            @(posedge clk); #1;
            ins = $urandom;
            pick = $urandom_range(0, 9);
            ins[6:0] = ops[pick];
            if ((pick < 2) && ($urandom_range(0, 3) != 0))
                ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            in_instr  = ins;
            in_pc     = $urandom;
            in_rs1    = $urandom;
            in_rs2    = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_empty", {31'h0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
